// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Stateful half of the control unit. Holds the instruction register and the
// 3-bit sequencing state, decodes the IR opcode into one-hot instruction-class
// lines, and emits the per-state datapath strobes. It stalls in FETCH and MEM
// until the memory signals ready.
//
// Parameters:
//   IW         instruction width; opcode is ir[IW-1:IW-4]
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   instr_in   instruction word from memory (captured in FETCH when ready)
//   mem_ready  memory completed the current access this cycle
//   zero_flag  ALU compare result, used by BE in EXEC
//   state      current state {s2,s1,s0}
//   ir         instruction register
//   alu .. be  one-hot class decode of the IR opcode (valid in every state)
//   illegal    opcode outside the class map, flagged in DECODE
//   mem_req .. sp_dec  datapath strobes
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int unsigned IW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr_in,
    input  logic          mem_ready,
    input  logic          zero_flag,
    output logic [2:0]    state,
    output logic [IW-1:0] ir,
    output logic          alu,
    output logic          ld,
    output logic          st,
    output logic          push,
    output logic          pop,
    output logic          jump,
    output logic          be,
    output logic          illegal,
    output logic          mem_req,
    output logic          mem_we,
    output logic          ir_we,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          reg_we,
    output logic          sp_inc,
    output logic          sp_dec
);

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100
    } state_e;

    // Kept as plain logic so the unused codes 101-111 are representable.
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic       cls_illegal;

    // Unqualified strobes; reset gating is applied afterwards.
    logic mem_req_c, mem_we_c, ir_we_c, pc_inc_c, pc_load_c;
    logic reg_we_c, sp_inc_c, sp_dec_c, illegal_c;

    // ---------------------------------------------------------------------
    // Class decode (combinational from ir, independent of state)
    // ---------------------------------------------------------------------
    assign opcode      = ir_q[IW-1:IW-4];
    assign alu         = ~opcode[3];
    assign ld          = (opcode == 4'b1000);
    assign st          = (opcode == 4'b1001);
    assign jump        = (opcode == 4'b1010);
    assign push        = (opcode == 4'b1011);
    assign pop         = (opcode == 4'b1100);
    assign be          = (opcode == 4'b1101);
    assign cls_illegal = (opcode[3:1] == 3'b111);

    // ---------------------------------------------------------------------
    // Next-state and strobe logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_we_c   = 1'b0;
        pc_inc_c  = 1'b0;
        pc_load_c = 1'b0;
        reg_we_c  = 1'b0;
        sp_inc_c  = 1'b0;
        sp_dec_c  = 1'b0;
        illegal_c = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c  = 1'b1;
                    pc_inc_c = 1'b1;
                    ir_d     = instr_in;
                    state_d  = StDecode;
                end
            end

            StDecode: begin
                if (jump) begin
                    pc_load_c = 1'b1;
                    state_d   = StFetch;
                end else if (cls_illegal) begin
                    illegal_c = 1'b1;
                    state_d   = StFetch;
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                state_d = StFetch;
                if (alu) begin
                    reg_we_c = 1'b1;
                end else if (be) begin
                    pc_load_c = zero_flag;
                end else if (push) begin
                    sp_dec_c = 1'b1;
                    state_d  = StMem;
                end else if (ld || st || pop) begin
                    state_d = StMem;
                end
            end

            StMem: begin
                mem_req_c = 1'b1;
                mem_we_c  = st || push;
                if (mem_ready) begin
                    if (ld || pop) begin
                        sp_inc_c = pop;
                        state_d  = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end

            StWb: begin
                reg_we_c = 1'b1;
                state_d  = StFetch;
            end

            default: begin
                // Unused codes recover to FETCH with everything quiet.
                state_d = StFetch;
            end
        endcase
    end

    // No strobe may escape while reset is held, even though the decode
    // above still sees the (cleared) state.
    always_comb begin
        mem_req = mem_req_c & ~rst;
        mem_we  = mem_we_c  & ~rst;
        ir_we   = ir_we_c   & ~rst;
        pc_inc  = pc_inc_c  & ~rst;
        pc_load = pc_load_c & ~rst;
        reg_we  = reg_we_c  & ~rst;
        sp_inc  = sp_inc_c  & ~rst;
        sp_dec  = sp_dec_c  & ~rst;
        illegal = illegal_c & ~rst;
    end

    // ---------------------------------------------------------------------
    // State and instruction registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign state = state_q;
    assign ir    = ir_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed, table-driven bench for control_sequencer. Each table row is one
// clock cycle: inputs applied just after the rising edge, outputs compared on
// the falling edge. Hand-written sequences cover stalls, mid-instruction
// reset and the unused state codes.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int unsigned IW = 18;

    logic          clk;
    logic          rst;
    logic [IW-1:0] instr_in;
    logic          mem_ready;
    logic          zero_flag;
    logic [2:0]    state;
    logic [IW-1:0] ir;
    logic          alu, ld, st, push, pop, jump, be, illegal;
    logic          mem_req, mem_we, ir_we, pc_inc, pc_load, reg_we, sp_inc, sp_dec;

    int checks = 0;
    int errors = 0;

    control_sequencer #(.IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_in  (instr_in),
        .mem_ready (mem_ready),
        .zero_flag (zero_flag),
        .state     (state),
        .ir        (ir),
        .alu       (alu),
        .ld        (ld),
        .st        (st),
        .push      (push),
        .pop       (pop),
        .jump      (jump),
        .be        (be),
        .illegal   (illegal),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .reg_we    (reg_we),
        .sp_inc    (sp_inc),
        .sp_dec    (sp_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_we, ir_we, pc_inc, pc_load, reg_we, sp_inc, sp_dec, illegal}
    logic [8:0] strb;
    assign strb = {mem_req, mem_we, ir_we, pc_inc, pc_load, reg_we, sp_inc, sp_dec, illegal};

    // {alu, ld, st, push, pop, jump, be}
    logic [6:0] cls;
    assign cls = {alu, ld, st, push, pop, jump, be};

    localparam logic [8:0] S_NONE  = 9'b000000000;
    localparam logic [8:0] S_FETCH = 9'b101100000;
    localparam logic [8:0] S_REQ   = 9'b100000000;
    localparam logic [8:0] S_WR    = 9'b110000000;
    localparam logic [8:0] S_PCLD  = 9'b000010000;
    localparam logic [8:0] S_REGWE = 9'b000001000;
    localparam logic [8:0] S_POPM  = 9'b100000100;
    localparam logic [8:0] S_ILL   = 9'b000000001;

    localparam logic [6:0] C_ALU  = 7'b1000000;
    localparam logic [6:0] C_LD   = 7'b0100000;
    localparam logic [6:0] C_ST   = 7'b0010000;
    localparam logic [6:0] C_POP  = 7'b0000100;
    localparam logic [6:0] C_JUMP = 7'b0000010;
    localparam logic [6:0] C_BE   = 7'b0000001;
    localparam logic [6:0] C_NONE = 7'b0000000;

    // Filler instruction on non-FETCH cycles: if it were ever latched the
    // class lines would collapse to all-zero and the row check would catch it.
    localparam logic [IW-1:0] FILL = 18'h3C000;

    typedef struct {
        logic [IW-1:0] instr;
        logic          rdy;
        logic          zf;
        logic [2:0]    exp_state;
        logic [8:0]    exp_strb;
        logic [6:0]    exp_cls;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [IW-1:0] i, input logic r, input logic z,
                       input logic [2:0] s, input logic [8:0] b, input logic [6:0] c);
        vec_t v;
        v.instr = i; v.rdy = r; v.zf = z; v.exp_state = s; v.exp_strb = b; v.exp_cls = c;
        vecs.push_back(v);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int n_spdec, n_wr, n_irwe, n_spinc;
    logic [2:0] bd_code;

    initial begin
        rst       = 1'b1;
        instr_in  = '0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;

        // ---------------- reset state ----------------
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_cls", 32'(cls), 32'(C_ALU));
        chk("rst_strb", 32'(strb), 32'(S_NONE));
        next_cycle();
        rst = 1'b0;

        // ---------------- table ----------------
        // LD
        add(18'h20000, 1, 0, 3'b000, S_FETCH, C_ALU);
        add(FILL,      1, 0, 3'b001, S_NONE,  C_LD);
        add(FILL,      1, 0, 3'b010, S_NONE,  C_LD);
        add(FILL,      1, 0, 3'b011, S_REQ,   C_LD);
        add(FILL,      1, 0, 3'b100, S_REGWE, C_LD);
        // BE taken
        add(18'h34000, 1, 0, 3'b000, S_FETCH, C_LD);
        add(FILL,      1, 0, 3'b001, S_NONE,  C_BE);
        add(FILL,      1, 1, 3'b010, S_PCLD,  C_BE);
        // BE not taken; zero_flag high in DECODE must be ignored
        add(18'h34000, 1, 1, 3'b000, S_FETCH, C_BE);
        add(FILL,      1, 1, 3'b001, S_NONE,  C_BE);
        add(FILL,      1, 0, 3'b010, S_NONE,  C_BE);
        // ALU
        add(18'h04000, 1, 0, 3'b000, S_FETCH, C_BE);
        add(FILL,      1, 0, 3'b001, S_NONE,  C_ALU);
        add(FILL,      1, 0, 3'b010, S_REGWE, C_ALU);
        // ST
        add(18'h24000, 1, 0, 3'b000, S_FETCH, C_ALU);
        add(FILL,      1, 0, 3'b001, S_NONE,  C_ST);
        add(FILL,      1, 0, 3'b010, S_NONE,  C_ST);
        add(FILL,      1, 0, 3'b011, S_WR,    C_ST);
        // JUMP
        add(18'h28000, 1, 0, 3'b000, S_FETCH, C_ST);
        add(FILL,      1, 0, 3'b001, S_PCLD,  C_JUMP);
        // POP
        add(18'h30000, 1, 0, 3'b000, S_FETCH, C_JUMP);
        add(FILL,      1, 0, 3'b001, S_NONE,  C_POP);
        add(FILL,      1, 0, 3'b010, S_NONE,  C_POP);
        add(FILL,      1, 0, 3'b011, S_POPM,  C_POP);
        add(FILL,      1, 0, 3'b100, S_REGWE, C_POP);
        // FETCH stall, then illegal opcode
        add(18'h38000, 0, 0, 3'b000, S_REQ,   C_POP);
        add(18'h38000, 1, 0, 3'b000, S_FETCH, C_POP);
        add(FILL,      1, 0, 3'b001, S_ILL,   C_NONE);
        add(FILL,      0, 0, 3'b000, S_REQ,   C_NONE);

        foreach (vecs[i]) begin
            instr_in  = vecs[i].instr;
            mem_ready = vecs[i].rdy;
            zero_flag = vecs[i].zf;
            @(negedge clk);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            chk($sformatf("v%0d_strb", i), 32'(strb), 32'(vecs[i].exp_strb));
            chk($sformatf("v%0d_cls", i), 32'(cls), 32'(vecs[i].exp_cls));
            next_cycle();
        end
        chk("illegal_ir", 32'(ir), 32'(18'h38000));

        // ---------------- PUSH with three MEM wait cycles ----------------
        n_spdec = 0; n_wr = 0; n_irwe = 0;
        for (int c = 0; c < 8; c++) begin
            instr_in  = (c == 0) ? 18'h2C000 : FILL;
            mem_ready = (c == 0 || c == 6) ? 1'b1 : 1'b0;
            zero_flag = 1'b0;
            @(negedge clk);
            if (sp_dec) n_spdec++;
            if (mem_req && mem_we) n_wr++;
            if (ir_we) n_irwe++;
            if (c == 6) chk("push_last_mem_state", 32'(state), 32'd3);
            if (c == 7) chk("push_back_to_fetch", 32'(state), 32'd0);
            next_cycle();
        end
        chk("push_sp_dec_count", 32'(n_spdec), 32'd1);
        chk("push_mem_we_count", 32'(n_wr), 32'd4);
        chk("push_ir_we_count", 32'(n_irwe), 32'd1);

        // ---------------- reset during a POP MEM stall ----------------
        for (int c = 0; c < 5; c++) begin
            instr_in  = (c == 0) ? 18'h30000 : FILL;
            mem_ready = (c == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (c < 4) next_cycle();
        end
        chk("pop_stall_state", 32'(state), 32'd3);
        chk("pop_stall_strb", 32'(strb), 32'(S_REQ));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_ir", 32'(ir), 32'd0);
        chk("midrst_strb", 32'(strb), 32'(S_NONE));
        chk("midrst_cls", 32'(cls), 32'(C_ALU));
        mem_ready = 1'b1;
        n_spinc = 0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            if (sp_inc) n_spinc++;
            chk($sformatf("rsthold%0d_strb", c), 32'(strb), 32'(S_NONE));
        end
        chk("midrst_sp_inc_count", 32'(n_spinc), 32'd0);
        next_cycle();
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_strb", 32'(strb), 32'(S_REQ));

        // ---------------- unused state codes ----------------
        for (int k = 5; k < 8; k++) begin
            bd_code = 3'(k);
            #1;
            force dut.state_q = bd_code;
            #1;
            chk($sformatf("bd%0d_state", k), 32'(state), 32'(bd_code));
            chk($sformatf("bd%0d_strb", k), 32'(strb), 32'(S_NONE));
            chk($sformatf("bd%0d_next", k), 32'(dut.state_d), 32'd0);
            release dut.state_q;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bd%0d_recover", k), 32'(state), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
